mult_axi_master: RTL
====================

// Module: mult_axi_master
// PURPOSE
//  AXI4-Lite master that drives the multiplier slave. Takes one operand pair on a
//  valid/ready command port, writes it to operand regs 0x00/0x04, then reads result
//  regs 0x08/0x0C. Returns both words on a valid/ready result port.
//  Sits directly upstream of the multiplier; its m2_axi_* bus connects 1:1 to s2_axi_*.
// PARAMETERS
//  DATA_WIDTH  32   AXI data width and operand/result width
//  ADDR_WIDTH  8    AXI address width
//  TIMEOUT     64   max cycles to wait for any single AXI handshake before abort (>=2)
// PORTS
//  m2_axi_aclk     in   1             clock, all logic on rising edge
//  m2_axi_aresetn  in   1             synchronous active-low reset
//  cmd_valid       in   1             operand pair valid
//  cmd_ready       out  1             high only in IDLE
//  cmd_a / cmd_b   in   DATA_WIDTH    operands (to 0x00 / 0x04)
//  res_valid       out  1             result pair valid
//  res_ready       in   1             consumer accepts result
//  res_lo / res_hi out  DATA_WIDTH    words read from 0x08 / 0x0C
//  res_err         out  1             any nonzero resp or timeout during this transaction
//  m2_axi_awaddr/awvalid out ADDR_WIDTH/1, awready in 1    write address channel
//  m2_axi_wdata/wstrb/wvalid out DATA_WIDTH/DATA_WIDTH/8/1, wready in 1  write data
//  m2_axi_bresp in 1, bvalid in 1, bready out 1           write response
//  m2_axi_araddr/arvalid out ADDR_WIDTH/1, arready in 1    read address
//  m2_axi_rdata in DATA_WIDTH, rresp in 1, rvalid in 1, rready out 1  read data
// BEHAVIOUR
//  Reset: all valid/ready outputs 0, addr/data/wstrb 0, res_lo/hi/err 0, FSM=IDLE,
//   timer 0. Reset mid-transaction abandons it at once; no bus output held.
//  FSM: IDLE -> WR_A -> WR_B -> RD_LO -> RD_HI -> RESP -> IDLE.
//  IDLE: cmd_ready=1; cmd_valid&cmd_ready latches a,b, clears err, -> WR_A.
//  WR_x (addr 0x00 then 0x04): awvalid,wvalid rise together the cycle after entry,
//   wstrb all ones. Each drops the cycle after its own handshake; addr/data are stable
//   while valid. After both handshakes, bready=1 until bvalid; then -> next state.
//   bresp!=0 sets err, sequence continues.
//  RD_x (addr 0x08 then 0x0C): arvalid held until arready; then rready=1 until rvalid.
//   rdata is captured into res_lo/res_hi on rvalid&rready; rresp!=0 sets err.
//  Simultaneous aw/w/ar ready with valid in entry cycle is legal; the minimum per write
//   is 2 cycles and the minimum per read is 2 cycles.
//  RESP: res_valid=1 and outputs stable until res_ready; then -> IDLE.
//   cmd_ready returns the following cycle.
//  Timer restarts on every state/handshake progress. On reaching TIMEOUT with no
//   progress: drop all bus valids/readies, set err, -> RESP (res words hold partial
//   or 0).
//  Never more than one outstanding AXI transaction; no read issued before last bvalid.
// TESTING
//  1 Always-ready slave model, cmd a=6 b=7 -> writes 6@0x00, 7@0x04; res_lo=42,
//    res_hi=0, err=0.
//  2 Slave delays awready 3 cycles, wready 1 cycle -> awvalid held 3 cycles, wvalid
//    dropped independently; the stored data is correct.
//  3 a=0xFFFFFFFF b=2 -> res_lo=0xFFFFFFFE, res_hi=0x1; res_valid held while
//    res_ready=0 for 5 cycles.
//  4 Slave never asserts bvalid -> after TIMEOUT cycles, res_valid=1, res_err=1,
//    bready=0.
//  5 rresp=1 on 0x0C read -> res_err=1, res_lo still correct.
//  6 aresetn=0 during RD_LO -> the next cycle has all bus outputs 0 and cmd_ready=1
//    after release; the new cmd runs cleanly.

Source files
------------

// File: rtl/mult_axi_master.sv
// AXI4-Lite master for the multiplier slave: writes an operand pair,
// reads back the 2-word product, returns it on a valid/ready port.
module mult_axi_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                    m2_axi_aclk,
  input  logic                    m2_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_lo,
  output logic [DATA_WIDTH-1:0]   res_hi,
  output logic                    res_err,
  output logic [ADDR_WIDTH-1:0]   m2_axi_awaddr,
  output logic                    m2_axi_awvalid,
  input  logic                    m2_axi_awready,
  output logic [DATA_WIDTH-1:0]   m2_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m2_axi_wstrb,
  output logic                    m2_axi_wvalid,
  input  logic                    m2_axi_wready,
  input  logic                    m2_axi_bresp,
  input  logic                    m2_axi_bvalid,
  output logic                    m2_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m2_axi_araddr,
  output logic                    m2_axi_arvalid,
  input  logic                    m2_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m2_axi_rdata,
  input  logic                    m2_axi_rresp,
  input  logic                    m2_axi_rvalid,
  output logic                    m2_axi_rready
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR_A, WR_B, RD_LO, RD_HI, RESP
  } state_t;

  state_t                  state_q, state_d;
  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    bready_q, bready_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]           wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   b_q, b_d;
  logic [DATA_WIDTH-1:0]   lo_q, lo_d;
  logic [DATA_WIDTH-1:0]   hi_q, hi_d;
  logic                    err_q, err_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    progress;

  always_ff @(posedge m2_axi_aclk) begin
    if (!m2_axi_aresetn) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      b_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      err_q     <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      b_q       <= b_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      err_q     <= err_d;
      timer_q   <= timer_d;
    end
  end

  // Bus valids are registered so they appear in the first cycle of a state.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    b_d       = b_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    err_d     = err_q;
    timer_d   = '0;
    progress  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          b_d       = cmd_b;
          err_d     = 1'b0;
          lo_d      = '0;
          hi_d      = '0;
          awaddr_d  = ADDR_WIDTH'(8'h00);
          wdata_d   = cmd_a;
          wstrb_d   = '1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = WR_A;
        end
      end
      WR_A, WR_B: begin
        if (awvalid_q && m2_axi_awready) begin
          awvalid_d = 1'b0;
          progress  = 1'b1;
        end
        if (wvalid_q && m2_axi_wready) begin
          wvalid_d = 1'b0;
          progress = 1'b1;
        end
        if (bready_q && m2_axi_bvalid) begin
          bready_d = 1'b0;
          progress = 1'b1;
          if (m2_axi_bresp) err_d = 1'b1;
          if (state_q == WR_A) begin
            awaddr_d  = ADDR_WIDTH'(8'h04);
            wdata_d   = b_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_B;
          end else begin
            araddr_d  = ADDR_WIDTH'(8'h08);
            arvalid_d = 1'b1;
            state_d   = RD_LO;
          end
        end else begin
          bready_d = !awvalid_d && !wvalid_d;
        end
      end
      RD_LO, RD_HI: begin
        if (arvalid_q && m2_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          progress  = 1'b1;
        end
        if (rready_q && m2_axi_rvalid) begin
          rready_d = 1'b0;
          progress = 1'b1;
          if (m2_axi_rresp) err_d = 1'b1;
          if (state_q == RD_LO) begin
            lo_d      = m2_axi_rdata;
            araddr_d  = ADDR_WIDTH'(8'h0C);
            arvalid_d = 1'b1;
            state_d   = RD_HI;
          end else begin
            hi_d    = m2_axi_rdata;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Watchdog: any stall on a single handshake aborts the whole sequence.
    if (state_q inside {WR_A, WR_B, RD_LO, RD_HI}) begin
      if (progress) begin
        timer_d = '0;
      end else if (timer_q == TW'(TIMEOUT - 1)) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        err_d     = 1'b1;
        state_d   = RESP;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  assign cmd_ready      = (state_q == IDLE) && m2_axi_aresetn;
  assign res_valid      = (state_q == RESP);
  assign res_lo         = lo_q;
  assign res_hi         = hi_q;
  assign res_err        = err_q;
  assign m2_axi_awaddr  = awaddr_q;
  assign m2_axi_awvalid = awvalid_q;
  assign m2_axi_wdata   = wdata_q;
  assign m2_axi_wstrb   = wstrb_q;
  assign m2_axi_wvalid  = wvalid_q;
  assign m2_axi_bready  = bready_q;
  assign m2_axi_araddr  = araddr_q;
  assign m2_axi_arvalid = arvalid_q;
  assign m2_axi_rready  = rready_q;

endmodule
